pe_simd_mac: RTL and testbench
==============================

Name: pe_simd_mac

Overview:
- Next-generation systolic-array processing element with LANES parallel multiply-accumulate lanes per PE.
- Runtime signed/unsigned mode, valid-qualified operand beats, registered operand forwarding to the right/below neighbour, per-lane sticky overflow, beat counter.
- Explicit drain handshake: the array controller collects results under backpressure before the next operation.
- Tiles a 2-D array exactly like the current single-lane PE; one instance per array cell.

Parameters:
DATA_WIDTH, 8, width of each lane operand A/B
BUS_WIDTH, 32, width of each lane accumulator (must be >= 2*DATA_WIDTH)
LANES, 4, number of parallel MAC lanes
CNT_WIDTH, 16, width of accepted-beat counter

Ports:
clk_i  in  1  clock; all logic on rising edge
rst_i  in  1  synchronous, active-high reset
start_operation_i  in  1  level; high = operation window
signed_mode_i  in  1  1 = signed, 0 = unsigned; sampled on IDLE->ACCUM
data_valid_i  in  1  qualifies data_A_i/data_B_i beat
data_A_i  in  LANES*DATA_WIDTH  lane l at [l*DATA_WIDTH +: DATA_WIDTH]
data_B_i  in  LANES*DATA_WIDTH  same packing
data_A_o  out  LANES*DATA_WIDTH  registered forward of data_A_i
data_B_o  out  LANES*DATA_WIDTH  registered forward of data_B_i
data_valid_o  out  1  registered forward of data_valid_i
accum_o  out  LANES*BUS_WIDTH  lane accumulators, packed as inputs
accum_valid_o  out  1  result valid (DRAIN)
accum_ready_i  in  1  consumer accepts result
ov_flag_o  out  LANES  per-lane sticky overflow
mac_count_o  out  CNT_WIDTH  accepted beats this operation
busy_o  out  1  state != IDLE

Behaviour:
- Reset (rst_i=1 at clock edge):
  - state=IDLE
  - all outputs 0; accumulators, ov flags and count 0
  - Reset mid-ACCUM or mid-DRAIN aborts the operation; no drain occurs.
- FSM:
  - IDLE: start_operation_i=1 -> ACCUM. On that edge: clear accumulators, ov_flag_o and mac_count_o; latch signed_mode_i.
  - ACCUM, start_operation_i=1 and data_valid_i=1: per lane acc += ext(A*B); mac_count_o += 1, saturating at 2^CNT_WIDTH-1.
  - ACCUM, start_operation_i=0 -> DRAIN. Any beat presented on that cycle is not accumulated.
  - DRAIN: accum_valid_o=1 and accum_o stable. accum_ready_i=1 -> IDLE, with accum_valid_o=0 from the next cycle.
  - start_operation_i is ignored in DRAIN. If it is still high on return to IDLE, a new op starts one cycle later.
- accum_o continuously reflects the accumulators. The value holds through IDLE until the next start clears it.
- Forwarding (1-cycle latency):
  - In ACCUM with start_operation_i=1: data_valid_o <= data_valid_i. data_A_o/data_B_o <= inputs when data_valid_i=1, otherwise they hold.
  - Outside ACCUM: data_valid_o=0 and data_*_o=0.
- Arithmetic:
  - Signed mode: product is 2*DATA_WIDTH signed, sign-extended to BUS_WIDTH.
  - Unsigned mode: product is 2*DATA_WIDTH unsigned, zero-extended to BUS_WIDTH.
  - Lane overflow, signed mode: acc and addend signs equal and the result sign differs.
  - Lane overflow, unsigned mode: carry out of bit BUS_WIDTH-1.
  - On overflow, ov_flag_o[l] is set and stays set until the next start.
  - Default result on overflow: wrap modulo 2^BUS_WIDTH.
- Lanes are fully independent; an overflow in one lane does not affect the others.

Optional Feature:
- Macro: PE_SATURATE_EN.
- Defined: an overflowing lane clamps to its extreme value, and later beats add from the clamped value.
  - Signed positive overflow: 2^(BUS_WIDTH-1)-1.
  - Signed negative overflow: -2^(BUS_WIDTH-1).
  - Unsigned overflow: 2^BUS_WIDTH-1.
  - ov_flag_o is still set.
- Undefined: wrap-around as above; no clamp logic is synthesised.

Test Plan:
1. Signed, LANES=4: A={1,-2,3,-4}, B={5,6,-7,-8}, 3 valid beats, then start low -> DRAIN with accum_o={15,-36,-63,96}, mac_count_o=3, ov_flag_o=0, accum_valid_o=1 until accum_ready_i.
2. Unsigned: A=255, B=255 all lanes, 2 beats -> each lane 130050, ov_flag_o=0. Same data in signed mode -> each lane 2 (-1*-1 twice).
3. BUS_WIDTH=16, DATA_WIDTH=8, signed, A=127, B=127, 3 beats:
   - Without PE_SATURATE_EN -> lane = -17149, ov_flag_o[lane]=1.
   - With PE_SATURATE_EN -> lane = 32767, ov_flag_o[lane]=1.
4. data_valid_i pattern 1,0,1 with A=2,4,6 and B=1 -> mac_count_o=2, acc=8. data_valid_o=1,0,1 delayed one cycle; data_A_o holds 2 during the gap.
5. DRAIN with accum_ready_i low 5 cycles and start_operation_i high:
   - accum_o and accum_valid_o stable, busy_o=1.
   - Ready pulse -> IDLE, then ACCUM next cycle with accum_o=0 and ov_flag_o cleared.
6. rst_i asserted mid-ACCUM after 2 beats -> next cycle all outputs 0, busy_o=0; no accum_valid_o pulse.

Source files
------------

// File: rtl/pe_simd_mac_if.sv
// rtl/pe_simd_mac_if.sv - operand, result and status bundle for one pe_simd_mac array cell
interface pe_simd_mac_if #(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_WIDTH  = 32,
    parameter int LANES      = 4,
    parameter int CNT_WIDTH  = 16
);
    logic                          start_operation_i;
    logic                          signed_mode_i;
    logic                          data_valid_i;
    logic [LANES*DATA_WIDTH-1:0]   data_A_i;
    logic [LANES*DATA_WIDTH-1:0]   data_B_i;
    logic [LANES*DATA_WIDTH-1:0]   data_A_o;
    logic [LANES*DATA_WIDTH-1:0]   data_B_o;
    logic                          data_valid_o;
    logic [LANES*BUS_WIDTH-1:0]    accum_o;
    logic                          accum_valid_o;
    logic                          accum_ready_i;
    logic [LANES-1:0]              ov_flag_o;
    logic [CNT_WIDTH-1:0]          mac_count_o;
    logic                          busy_o;

    modport master (
        output start_operation_i, signed_mode_i, data_valid_i, data_A_i, data_B_i, accum_ready_i,
        input  data_A_o, data_B_o, data_valid_o, accum_o, accum_valid_o, ov_flag_o, mac_count_o, busy_o
    );

    modport slave (
        input  start_operation_i, signed_mode_i, data_valid_i, data_A_i, data_B_i, accum_ready_i,
        output data_A_o, data_B_o, data_valid_o, accum_o, accum_valid_o, ov_flag_o, mac_count_o, busy_o
    );
endinterface

// File: rtl/pe_simd_mac.sv
// rtl/pe_simd_mac.sv - multi-lane systolic MAC processing element with drain handshake
// Optional clamp-on-overflow per lane when PE_SATURATE_EN is defined; wrap-around otherwise.
module pe_simd_mac #(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_WIDTH  = 32,
    parameter int LANES      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    pe_simd_mac_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    state_t                      state;
    logic                        mode_q;
    logic                        busy_q;
    logic                        valid_q;
    logic                        dv_q;
    logic [LANES*DATA_WIDTH-1:0] a_q;
    logic [LANES*DATA_WIDTH-1:0] b_q;
    logic [CNT_WIDTH-1:0]        cnt_q;
    logic [LANES-1:0]            ov_q;
    logic [BUS_WIDTH-1:0]        acc_q  [LANES];
    logic [BUS_WIDTH-1:0]        acc_nx [LANES];
    logic [LANES-1:0]            lane_ov;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [DATA_WIDTH-1:0]          a;
        logic [DATA_WIDTH-1:0]          b;
        logic [2*DATA_WIDTH-1:0]        prod_u;
        logic signed [2*DATA_WIDTH-1:0] prod_s;
        logic [BUS_WIDTH-1:0]           ext_u;
        logic signed [BUS_WIDTH-1:0]    ext_s;
        logic [BUS_WIDTH-1:0]           addend;
        logic [BUS_WIDTH:0]             sum;

        assign a      = bus.data_A_i[l*DATA_WIDTH +: DATA_WIDTH];
        assign b      = bus.data_B_i[l*DATA_WIDTH +: DATA_WIDTH];
        // Both operands widened to 2*DATA_WIDTH so the low half of the product is exact.
        assign prod_u = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
        assign prod_s = $signed({{DATA_WIDTH{a[DATA_WIDTH-1]}}, a}) *
                        $signed({{DATA_WIDTH{b[DATA_WIDTH-1]}}, b});
        assign ext_u  = BUS_WIDTH'(prod_u);
        assign ext_s  = BUS_WIDTH'(prod_s);
        assign addend = mode_q ? ext_s : ext_u;
        assign sum    = {1'b0, acc_q[l]} + {1'b0, addend};

        assign lane_ov[l] = mode_q ? ((acc_q[l][BUS_WIDTH-1] == addend[BUS_WIDTH-1]) &&
                                      (sum[BUS_WIDTH-1] != acc_q[l][BUS_WIDTH-1]))
                                   : sum[BUS_WIDTH];

`ifdef PE_SATURATE_EN
        logic [BUS_WIDTH-1:0] sat_val;
        // On a signed overflow the accumulator sign tells the direction of the excursion.
        assign sat_val = !mode_q             ? {BUS_WIDTH{1'b1}} :
                         acc_q[l][BUS_WIDTH-1] ? {1'b1, {(BUS_WIDTH-1){1'b0}}}
                                               : {1'b0, {(BUS_WIDTH-1){1'b1}}};
        assign acc_nx[l] = lane_ov[l] ? sat_val : sum[BUS_WIDTH-1:0];
`else
        assign acc_nx[l] = sum[BUS_WIDTH-1:0];
`endif

        assign bus.accum_o[l*BUS_WIDTH +: BUS_WIDTH] = acc_q[l];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            dv_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            ov_q    <= '0;
            for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    dv_q <= 1'b0;
                    a_q  <= '0;
                    b_q  <= '0;
                    if (bus.start_operation_i) begin
                        state  <= ACCUM;
                        busy_q <= 1'b1;
                        mode_q <= bus.signed_mode_i;
                        cnt_q  <= '0;
                        ov_q   <= '0;
                        for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
                    end
                end
                ACCUM: begin
                    if (bus.start_operation_i) begin
                        dv_q <= bus.data_valid_i;
                        if (bus.data_valid_i) begin
                            a_q  <= bus.data_A_i;
                            b_q  <= bus.data_B_i;
                            ov_q <= ov_q | lane_ov;
                            for (int l = 0; l < LANES; l++) acc_q[l] <= acc_nx[l];
                            if (cnt_q != {CNT_WIDTH{1'b1}}) cnt_q <= cnt_q + CNT_WIDTH'(1);
                        end
                    end else begin
                        // Falling start closes the window; a beat on this cycle is dropped.
                        state   <= DRAIN;
                        valid_q <= 1'b1;
                        dv_q    <= 1'b0;
                        a_q     <= '0;
                        b_q     <= '0;
                    end
                end
                DRAIN: begin
                    if (bus.accum_ready_i) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_A_o      = a_q;
    assign bus.data_B_o      = b_q;
    assign bus.data_valid_o  = dv_q;
    assign bus.accum_valid_o = valid_q;
    assign bus.ov_flag_o     = ov_q;
    assign bus.mac_count_o   = cnt_q;
    assign bus.busy_o        = busy_q;
endmodule

// File: tb/tb_pe_simd_mac.sv
// tb/tb_pe_simd_mac.sv - directed bench for pe_simd_mac, 32-bit and 16-bit accumulator builds side by side
module tb_pe_simd_mac;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    pe_simd_mac_if #(.DATA_WIDTH(8), .BUS_WIDTH(32), .LANES(4), .CNT_WIDTH(16)) ifm ();
    pe_simd_mac_if #(.DATA_WIDTH(8), .BUS_WIDTH(16), .LANES(4), .CNT_WIDTH(16)) if16 ();

    assign if16.start_operation_i = ifm.start_operation_i;
    assign if16.signed_mode_i     = ifm.signed_mode_i;
    assign if16.data_valid_i      = ifm.data_valid_i;
    assign if16.data_A_i          = ifm.data_A_i;
    assign if16.data_B_i          = ifm.data_B_i;
    assign if16.accum_ready_i     = ifm.accum_ready_i;

    pe_simd_mac #(.DATA_WIDTH(8), .BUS_WIDTH(32), .LANES(4), .CNT_WIDTH(16)) u_dut (
        .clk_i (clk), .rst_i (rst), .bus (ifm)
    );
    pe_simd_mac #(.DATA_WIDTH(8), .BUS_WIDTH(16), .LANES(4), .CNT_WIDTH(16)) u_dut16 (
        .clk_i (clk), .rst_i (rst), .bus (if16)
    );

`ifdef PE_SATURATE_EN
    localparam logic [15:0] OVS16 = 16'h7FFF;
    localparam logic [15:0] OVU16 = 16'hFFFF;
`else
    localparam logic [15:0] OVS16 = 16'hBD03;
    localparam logic [15:0] OVU16 = 16'hFC02;
`endif

    function automatic logic [31:0] pk8(input int l0, input int l1, input int l2, input int l3);
        return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
    endfunction
    function automatic logic [127:0] pk32(input int l0, input int l1, input int l2, input int l3);
        return {32'(l3), 32'(l2), 32'(l1), 32'(l0)};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic op_start(input logic sm);
        ifm.start_operation_i = 1'b1;
        ifm.signed_mode_i     = sm;
        ifm.data_valid_i      = 1'b0;
        cyc();
    endtask

    task automatic beat(input logic [31:0] a, input logic [31:0] b, input logic dv);
        ifm.data_A_i     = a;
        ifm.data_B_i     = b;
        ifm.data_valid_i = dv;
        cyc();
    endtask

    task automatic op_end();
        ifm.start_operation_i = 1'b0;
        ifm.data_valid_i      = 1'b0;
        cyc();
    endtask

    task automatic release_drain();
        ifm.accum_ready_i = 1'b1;
        cyc();
        ifm.accum_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) cyc();
        checks++; if (ifm.accum_o !== 128'd0) begin errors++; $display("FAIL reset_accum: got %0h expected 0", ifm.accum_o); end
        checks++; if ({ifm.busy_o, ifm.accum_valid_o, ifm.data_valid_o} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {ifm.busy_o, ifm.accum_valid_o, ifm.data_valid_o}); end
        checks++; if ({ifm.ov_flag_o, ifm.mac_count_o, ifm.data_A_o} !== 52'd0) begin errors++; $display("FAIL reset_status: got %0h expected 0", {ifm.ov_flag_o, ifm.mac_count_o, ifm.data_A_o}); end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_signed_basic();
        op_start(1'b1);
        checks++; if (ifm.busy_o !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", ifm.busy_o); end
        repeat (3) beat(pk8(1, -2, 3, -4), pk8(5, 6, -7, -8), 1'b1);
        op_end();
        checks++; if (ifm.accum_o !== pk32(15, -36, -63, 96)) begin errors++; $display("FAIL basic_accum: got %0h expected %0h", ifm.accum_o, pk32(15, -36, -63, 96)); end
        checks++; if (ifm.mac_count_o !== 16'd3) begin errors++; $display("FAIL basic_count: got %0d expected 3", ifm.mac_count_o); end
        checks++; if (ifm.ov_flag_o !== 4'b0000) begin errors++; $display("FAIL basic_ov: got %b expected 0000", ifm.ov_flag_o); end
        checks++; if (ifm.accum_valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", ifm.accum_valid_o); end
        cyc();
        checks++; if (ifm.accum_valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid_hold: got %b expected 1", ifm.accum_valid_o); end
        release_drain();
        checks++; if ({ifm.accum_valid_o, ifm.busy_o} !== 2'b00) begin errors++; $display("FAIL basic_idle: got %b expected 00", {ifm.accum_valid_o, ifm.busy_o}); end
        checks++; if (ifm.accum_o !== pk32(15, -36, -63, 96)) begin errors++; $display("FAIL basic_accum_hold: got %0h expected %0h", ifm.accum_o, pk32(15, -36, -63, 96)); end
    endtask

    task automatic test_unsigned_vs_signed();
        op_start(1'b0);
        repeat (2) beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        op_end();
        checks++; if (ifm.accum_o !== pk32(130050, 130050, 130050, 130050)) begin errors++; $display("FAIL unsigned_accum: got %0h expected %0h", ifm.accum_o, pk32(130050, 130050, 130050, 130050)); end
        checks++; if (ifm.ov_flag_o !== 4'b0000) begin errors++; $display("FAIL unsigned_ov: got %b expected 0000", ifm.ov_flag_o); end
        checks++; if (if16.accum_o !== {4{OVU16}}) begin errors++; $display("FAIL unsigned16_accum: got %0h expected %0h", if16.accum_o, {4{OVU16}}); end
        checks++; if (if16.ov_flag_o !== 4'b1111) begin errors++; $display("FAIL unsigned16_ov: got %b expected 1111", if16.ov_flag_o); end
        release_drain();
        op_start(1'b1);
        repeat (2) beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        op_end();
        checks++; if (ifm.accum_o !== pk32(2, 2, 2, 2)) begin errors++; $display("FAIL signed_m1_accum: got %0h expected %0h", ifm.accum_o, pk32(2, 2, 2, 2)); end
        checks++; if ({ifm.ov_flag_o, if16.ov_flag_o} !== 8'h00) begin errors++; $display("FAIL signed_m1_ov: got %b expected 0", {ifm.ov_flag_o, if16.ov_flag_o}); end
        checks++; if (if16.accum_o !== {4{16'd2}}) begin errors++; $display("FAIL signed_m1_accum16: got %0h expected %0h", if16.accum_o, {4{16'd2}}); end
        release_drain();
    endtask

    task automatic test_overflow();
        op_start(1'b1);
        repeat (3) beat(pk8(127, 1, 127, 127), pk8(127, 1, 127, 127), 1'b1);
        op_end();
        checks++; if (if16.accum_o !== {OVS16, OVS16, 16'd3, OVS16}) begin errors++; $display("FAIL ovf16_accum: got %0h expected %0h", if16.accum_o, {OVS16, OVS16, 16'd3, OVS16}); end
        checks++; if (if16.ov_flag_o !== 4'b1101) begin errors++; $display("FAIL ovf16_flags: got %b expected 1101", if16.ov_flag_o); end
        checks++; if (ifm.accum_o !== pk32(48387, 3, 48387, 48387)) begin errors++; $display("FAIL ovf32_accum: got %0h expected %0h", ifm.accum_o, pk32(48387, 3, 48387, 48387)); end
        checks++; if (ifm.ov_flag_o !== 4'b0000) begin errors++; $display("FAIL ovf32_flags: got %b expected 0000", ifm.ov_flag_o); end
        release_drain();
    endtask

    task automatic test_forwarding();
        op_start(1'b0);
        beat(pk8(2, 2, 2, 2), pk8(1, 1, 1, 1), 1'b1);
        checks++; if ({ifm.data_valid_o, ifm.data_A_o} !== {1'b1, pk8(2, 2, 2, 2)}) begin errors++; $display("FAIL fwd_beat1: got %0h expected %0h", {ifm.data_valid_o, ifm.data_A_o}, {1'b1, pk8(2, 2, 2, 2)}); end
        beat(pk8(4, 4, 4, 4), pk8(1, 1, 1, 1), 1'b0);
        checks++; if ({ifm.data_valid_o, ifm.data_A_o} !== {1'b0, pk8(2, 2, 2, 2)}) begin errors++; $display("FAIL fwd_gap_hold: got %0h expected %0h", {ifm.data_valid_o, ifm.data_A_o}, {1'b0, pk8(2, 2, 2, 2)}); end
        beat(pk8(6, 6, 6, 6), pk8(1, 1, 1, 1), 1'b1);
        checks++; if ({ifm.data_valid_o, ifm.data_A_o, ifm.data_B_o} !== {1'b1, pk8(6, 6, 6, 6), pk8(1, 1, 1, 1)}) begin errors++; $display("FAIL fwd_beat3: got %0h expected %0h", {ifm.data_valid_o, ifm.data_A_o, ifm.data_B_o}, {1'b1, pk8(6, 6, 6, 6), pk8(1, 1, 1, 1)}); end
        op_end();
        checks++; if ({ifm.mac_count_o, ifm.accum_o} !== {16'd2, pk32(8, 8, 8, 8)}) begin errors++; $display("FAIL fwd_result: got %0h expected %0h", {ifm.mac_count_o, ifm.accum_o}, {16'd2, pk32(8, 8, 8, 8)}); end
        checks++; if ({ifm.data_valid_o, ifm.data_A_o, ifm.data_B_o} !== 65'd0) begin errors++; $display("FAIL fwd_drain_zero: got %0h expected 0", {ifm.data_valid_o, ifm.data_A_o, ifm.data_B_o}); end
        release_drain();
    endtask

    task automatic test_back_to_back();
        op_start(1'b1);
        repeat (3) beat(pk8(127, 1, 127, 127), pk8(127, 1, 127, 127), 1'b1);
        op_end();
        ifm.start_operation_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks++; if ({ifm.accum_valid_o, ifm.busy_o, ifm.accum_o} !== {2'b11, pk32(48387, 3, 48387, 48387)}) begin errors++; $display("FAIL bp_hold_%0d: got %0h expected %0h", i, {ifm.accum_valid_o, ifm.busy_o, ifm.accum_o}, {2'b11, pk32(48387, 3, 48387, 48387)}); end
        end
        release_drain();
        checks++; if ({ifm.accum_valid_o, ifm.busy_o} !== 2'b00) begin errors++; $display("FAIL bp_idle: got %b expected 00", {ifm.accum_valid_o, ifm.busy_o}); end
        cyc();
        checks++; if ({ifm.busy_o, ifm.mac_count_o, ifm.accum_o, if16.accum_o} !== {1'b1, 16'd0, 128'd0, 64'd0}) begin errors++; $display("FAIL bp_restart_clear: got %0h expected %0h", {ifm.busy_o, ifm.mac_count_o, ifm.accum_o, if16.accum_o}, {1'b1, 16'd0, 128'd0, 64'd0}); end
        checks++; if (if16.ov_flag_o !== 4'b0000) begin errors++; $display("FAIL bp_restart_ov: got %b expected 0000", if16.ov_flag_o); end
        op_end();
        release_drain();
    endtask

    task automatic test_reset_mid_op();
        op_start(1'b1);
        repeat (2) beat(pk8(3, 3, 3, 3), pk8(3, 3, 3, 3), 1'b1);
        rst = 1'b1;
        cyc();
        checks++; if ({ifm.busy_o, ifm.accum_valid_o, ifm.data_valid_o, ifm.mac_count_o, ifm.accum_o, ifm.data_A_o} !== 179'd0) begin errors++; $display("FAIL rst_mid_outputs: got %0h expected 0", {ifm.busy_o, ifm.accum_valid_o, ifm.data_valid_o, ifm.mac_count_o, ifm.accum_o, ifm.data_A_o}); end
        rst = 1'b0;
        ifm.start_operation_i = 1'b0;
        ifm.data_valid_i      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++; if ({ifm.accum_valid_o, ifm.busy_o} !== 2'b00) begin errors++; $display("FAIL rst_no_drain_%0d: got %b expected 00", i, {ifm.accum_valid_o, ifm.busy_o}); end
        end
    endtask

    initial begin
        ifm.start_operation_i = 1'b0;
        ifm.signed_mode_i     = 1'b0;
        ifm.data_valid_i      = 1'b0;
        ifm.data_A_i          = '0;
        ifm.data_B_i          = '0;
        ifm.accum_ready_i     = 1'b0;
        test_reset();
        test_signed_basic();
        test_unsigned_vs_signed();
        test_overflow();
        test_forwarding();
        test_back_to_back();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
